// File: rtl/calc_result_seq_pkg.sv
// Shared widths, FSM encoding, beat tags and the held result-set payload for calc_result_seq.
package calc_result_seq_pkg;

  localparam int unsigned ADD_W  = 7;
  localparam int unsigned SUB_W  = 7;
  localparam int unsigned MUL_W  = 12;
  localparam int unsigned DIV_W  = 6;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_ADD = 2'd0;
  localparam logic [SEL_W-1:0] SEL_SUB = 2'd1;
  localparam logic [SEL_W-1:0] SEL_MUL = 2'd2;
  localparam logic [SEL_W-1:0] SEL_DIV = 2'd3;

  typedef struct packed {
    logic [ADD_W-1:0] add;
    logic [SUB_W-1:0] sub;
    logic [MUL_W-1:0] mul;
    logic [DIV_W-1:0] div;
  } result_set_t;

endpackage

// File: rtl/calc_result_seq.sv
// Serialises one add/sub/mul/div result set into four tagged 12-bit beats
// under a valid/ready handshake.
module calc_result_seq
  import calc_result_seq_pkg::*;
#(
  parameter bit SUB_SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              i_valid,
  input  logic [ADD_W-1:0]  i_add,
  input  logic [SUB_W-1:0]  i_sub,
  input  logic [MUL_W-1:0]  i_mul,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_drop
);

  state_t            state, state_d;
  logic [SEL_W-1:0]  idx, idx_d;
  result_set_t       hold, hold_d;
  logic              accept;
  logic              valid_d, last_d, drop_d;
  logic [DATA_W-1:0] data_d;

  // Width-extend the field addressed by sel to the output width.
  function automatic logic [DATA_W-1:0] ext_sel(input result_set_t s, input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] r;
    r = DATA_W'(s.add);
    case (sel)
      SEL_ADD: r = DATA_W'(s.add);
      SEL_SUB: r = SUB_SIGNED ? DATA_W'($signed(s.sub)) : DATA_W'(s.sub);
      SEL_MUL: r = s.mul;
      SEL_DIV: r = DATA_W'(s.div);
      default: r = DATA_W'(s.add);
    endcase
    return r;
  endfunction

  // State, beat index, held set and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      idx     <= '0;
      hold    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= '0;
      o_last  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      hold    <= hold_d;
      o_valid <= valid_d;
      o_data  <= data_d;
      o_sel   <= idx_d;
      o_last  <= last_d;
      o_drop  <= drop_d;
    end
  end

  // Next state: a new set is taken when idle or on the final-beat handshake.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    accept  = i_valid && ((state == IDLE) ||
                          ((state == SEND) && (idx == SEL_DIV) && i_ready));
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (i_ready) begin
          if (idx == SEL_DIV) begin
            idx_d   = '0;
            state_d = accept ? SEND : IDLE;
          end else begin
            idx_d = idx + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output/datapath next values; beat data comes from the set being held next cycle.
  always_comb begin
    hold_d  = hold;
    if (accept) begin
      hold_d = '{add: i_add, sub: i_sub, mul: i_mul, div: i_div};
    end
    valid_d = (state_d == SEND);
    data_d  = ext_sel(hold_d, idx_d);
    last_d  = (state_d == SEND) && (idx_d == SEL_DIV);
    drop_d  = o_drop | (i_valid & ~accept);
  end

  assign o_busy = (state == SEND) && !((idx == SEL_DIV) && i_ready);

endmodule

// File: tb/tb_calc_result_seq.sv
// Directed bench for calc_result_seq: beat sequencing, extension, stalls, drops,
// back-to-back sets and asynchronous reset.
module tb_calc_result_seq;

  logic        clk = 1'b0;
  logic        rstb;
  logic        i_valid;
  logic [6:0]  i_add;
  logic [6:0]  i_sub;
  logic [11:0] i_mul;
  logic [5:0]  i_div;
  logic        i_ready;

  logic        o_valid, o_last, o_busy, o_drop;
  logic [11:0] o_data;
  logic [1:0]  o_sel;
  logic        u_valid, u_last, u_busy, u_drop;
  logic [11:0] u_data;
  logic [1:0]  u_sel;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  calc_result_seq #(.SUB_SIGNED(1'b1)) dut (
    .clk(clk), .rstb(rstb), .i_valid(i_valid), .i_add(i_add), .i_sub(i_sub),
    .i_mul(i_mul), .i_div(i_div), .i_ready(i_ready), .o_valid(o_valid),
    .o_data(o_data), .o_sel(o_sel), .o_last(o_last), .o_busy(o_busy), .o_drop(o_drop)
  );

  calc_result_seq #(.SUB_SIGNED(1'b0)) dut_u (
    .clk(clk), .rstb(rstb), .i_valid(i_valid), .i_add(i_add), .i_sub(i_sub),
    .i_mul(i_mul), .i_div(i_div), .i_ready(i_ready), .o_valid(u_valid),
    .o_data(u_data), .o_sel(u_sel), .o_last(u_last), .o_busy(u_busy), .o_drop(u_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic beat(input string tag, input logic [1:0] sel, input logic [11:0] data);
    chk({tag, ".valid"}, 12'(o_valid), 12'd1);
    chk({tag, ".sel"},   12'(o_sel),   12'(sel));
    chk({tag, ".data"},  o_data,       data);
    chk({tag, ".last"},  12'(o_last),  12'(sel == 2'd3));
  endtask

  task automatic send_set(input logic [6:0] a, input logic [6:0] s,
                          input logic [11:0] m, input logic [5:0] d);
    i_valid = 1'b1;
    i_add = a; i_sub = s; i_mul = m; i_div = d;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; i_valid = 1'b0; i_add = '0; i_sub = '0; i_mul = '0; i_div = '0;
    i_ready = 1'b1;
    repeat (2) tick();
    chk("rst.valid", 12'(o_valid), 12'd0);
    chk("rst.data",  o_data,       12'd0);
    chk("rst.sel",   12'(o_sel),   12'd0);
    chk("rst.last",  12'(o_last),  12'd0);
    chk("rst.drop",  12'(o_drop),  12'd0);
    chk("rst.busy",  12'(o_busy),  12'd0);
    rstb = 1'b1;
    tick();

    // Basic four-beat set: 4+2, 4-2, 4*2, 4/2
    send_set(7'd6, 7'd2, 12'd8, 6'd2);
    chk("t1.busy0", 12'(o_busy), 12'd1);
    beat("t1.b0", 2'd0, 12'd6); tick();
    beat("t1.b1", 2'd1, 12'd2); tick();
    beat("t1.b2", 2'd2, 12'd8); tick();
    beat("t1.b3", 2'd3, 12'd2);
    chk("t1.busy3", 12'(o_busy), 12'd0);
    tick();
    chk("t1.idle", 12'(o_valid), 12'd0);
    chk("t1.busy_idle", 12'(o_busy), 12'd0);

    // Negative difference 5-6: signed vs unsigned extension
    send_set(7'd11, 7'h7F, 12'd30, 6'd0);
    beat("t2.b0", 2'd0, 12'd11); tick();
    beat("t2.b1", 2'd1, 12'hFFF);
    chk("t2.u_sel", 12'(u_sel), 12'd1);
    chk("t2.u_data", u_data, 12'h07F);
    tick();
    beat("t2.b2", 2'd2, 12'd30); tick();
    beat("t2.b3", 2'd3, 12'd0); tick();
    chk("t2.idle", 12'(o_valid), 12'd0);

    // Backpressure on the mul beat
    send_set(7'd6, 7'd2, 12'd8, 6'd2);
    beat("t3.b0", 2'd0, 12'd6); tick();
    beat("t3.b1", 2'd1, 12'd2); tick();
    beat("t3.b2", 2'd2, 12'd8);
    i_ready = 1'b0;
    chk("t3.busy_stall", 12'(o_busy), 12'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      beat("t3.hold", 2'd2, 12'd8);
    end
    i_ready = 1'b1;
    tick();
    beat("t3.b3", 2'd3, 12'd2); tick();
    chk("t3.idle", 12'(o_valid), 12'd0);

    // Set offered mid-transfer is dropped, original set intact
    send_set(7'd6, 7'd2, 12'd8, 6'd2);
    beat("t4.b0", 2'd0, 12'd6); tick();
    beat("t4.b1", 2'd1, 12'd2);
    i_valid = 1'b1; i_add = 7'd50; i_sub = 7'd40; i_mul = 12'd100; i_div = 6'd33;
    tick();
    i_valid = 1'b0;
    chk("t4.drop", 12'(o_drop), 12'd1);
    beat("t4.b2", 2'd2, 12'd8); tick();
    beat("t4.b3", 2'd3, 12'd2); tick();
    chk("t4.idle", 12'(o_valid), 12'd0);
    chk("t4.drop_sticky", 12'(o_drop), 12'd1);

    // Back-to-back: 7+2, 7-2, 7*2, 7/2 accepted on the final handshake
    send_set(7'd6, 7'd2, 12'd8, 6'd2);
    beat("t5.b0", 2'd0, 12'd6); tick();
    beat("t5.b1", 2'd1, 12'd2); tick();
    beat("t5.b2", 2'd2, 12'd8); tick();
    beat("t5.b3", 2'd3, 12'd2);
    i_valid = 1'b1; i_add = 7'd9; i_sub = 7'd5; i_mul = 12'd14; i_div = 6'd3;
    chk("t5.busy_b2b", 12'(o_busy), 12'd0);
    tick();
    i_valid = 1'b0;
    beat("t5.n0", 2'd0, 12'd9); tick();
    beat("t5.n1", 2'd1, 12'd5); tick();
    beat("t5.n2", 2'd2, 12'd14); tick();
    beat("t5.n3", 2'd3, 12'd3); tick();
    chk("t5.idle", 12'(o_valid), 12'd0);

    // Asynchronous reset during the mul beat
    send_set(7'd6, 7'd2, 12'd8, 6'd2);
    beat("t6.b0", 2'd0, 12'd6); tick();
    beat("t6.b1", 2'd1, 12'd2); tick();
    beat("t6.b2", 2'd2, 12'd8);
    #2 rstb = 1'b0;
    #1;
    chk("t6.async_valid", 12'(o_valid), 12'd0);
    chk("t6.async_sel",   12'(o_sel),   12'd0);
    chk("t6.async_data",  o_data,       12'd0);
    chk("t6.async_drop",  12'(o_drop),  12'd0);
    tick();
    rstb = 1'b1;
    tick();
    chk("t6.no_beats", 12'(o_valid), 12'd0);
    send_set(7'd9, 7'd5, 12'd14, 6'd3);
    beat("t6.n0", 2'd0, 12'd9); tick();
    beat("t6.n1", 2'd1, 12'd5); tick();
    beat("t6.n2", 2'd2, 12'd14); tick();
    beat("t6.n3", 2'd3, 12'd3); tick();
    chk("t6.idle", 12'(o_valid), 12'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/calc_result_seq.md
CALC_RESULT_SEQ -- requirements
Module: calc_result_seq

Interface
REQ-001 Parameter SUB_SIGNED, default 1: 1 = sign-extend i_sub (bit 6) to 12 bits; 0 = zero-extend.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstb  input  1  reset; asynchronous, active-low.
REQ-004 i_valid  input  1  result set on i_add/i_sub/i_mul/i_div is valid this cycle.
REQ-005 i_add  input  7  sum from upstream calculator.
REQ-006 i_sub  input  7  difference from upstream calculator.
REQ-007 i_mul  input  12  product from upstream calculator.
REQ-008 i_div  input  6  quotient from upstream calculator.
REQ-009 i_ready  input  1  downstream accepts o_data this cycle.
REQ-010 o_valid  output  1  o_data/o_sel/o_last hold a beat; registered.
REQ-011 o_data  output  12  current result, width-extended to 12 bits; registered.
REQ-012 o_sel  output  2  beat tag: 0=add, 1=sub, 2=mul, 3=div; registered.
REQ-013 o_last  output  1  high with the div beat (o_sel=3); registered.
REQ-014 o_busy  output  1  a set is being sent and the next i_valid would not be accepted.
REQ-015 o_drop  output  1  sticky flag: at least one set discarded since reset.

Function
REQ-016 The block shall capture all four inputs into holding registers when i_valid is high and the set is accepted (REQ-019).
REQ-017 The FSM shall have two states, IDLE and SEND, plus a 2-bit beat index 0..3.
REQ-018 The FSM shall go IDLE -> SEND on an accepted i_valid, with index 0 and o_valid=1 from the next cycle (latency 1 clock).
REQ-019 A set shall be accepted when state=IDLE, or when state=SEND with index=3 and i_ready=1 (back-to-back, no bubble).
REQ-020 In SEND the beat shall advance only when o_valid and i_ready are both high; o_data/o_sel shall hold while i_ready is low.
REQ-021 On the handshake of index 3, the FSM shall go to IDLE with o_valid=0, unless a new set is accepted in the same cycle; in that case it stays in SEND with index 0.
REQ-022 Extension: add and div zero-extended; mul passed through; sub per SUB_SIGNED.
REQ-023 An i_valid that is not accepted shall be discarded and shall set o_drop; held data shall be unaffected.
REQ-024 o_busy shall equal (state=SEND) AND NOT (index=3 AND i_ready); it is combinational.
REQ-025 o_last shall be high exactly when o_valid=1 and o_sel=3.

Reset
REQ-026 On rstb low, the block shall asynchronously force state=IDLE, index=0, o_valid=0, o_data=0, o_sel=0, o_last=0, o_drop=0, and holding registers=0.
REQ-027 A reset mid-set shall abort the set with no further beats; the first i_valid after rstb rises shall be accepted normally.

Structure
REQ-028 A shared package shall hold the state encoding (IDLE/SEND), the o_sel tag constants (SEL_ADD..SEL_DIV), and the widths 7/7/12/6/12.
REQ-029 The block shall be a single module with no sub-module; the 4:1 extend-and-select shall be a local combinational function/block.

Verification
REQ-030 Inputs add=6, sub=2, mul=8, div=2 (x=4, y=2), i_ready=1 -> four consecutive beats: o_data 6, 2, 8, 2; o_sel 0..3; o_last on beat 4.
REQ-031 x=5, y=6: sub=7'h7F, SUB_SIGNED=1 -> sub beat o_data=12'hFFF; with SUB_SIGNED=0 -> 12'h07F.
REQ-032 i_ready held low 3 cycles during the mul beat -> o_data=8 and o_sel=2 stable for those cycles; the div beat follows one cycle after i_ready rises.
REQ-033 i_valid during beat 1 -> set discarded, o_drop=1 and stays 1; the original set completes unchanged.
REQ-034 New i_valid coincident with the index-3 handshake (x=7, y=2 set) -> next cycle o_valid=1, o_sel=0, o_data=9, no idle gap.
REQ-035 rstb pulsed low during beat 2 -> o_valid=0 immediately (asynchronous); after release, a fresh set produces all four beats from o_sel=0.
